// File: rtl/hazard_detection_unit_pkg.sv
// hazard_detection_unit_pkg: shared pipeline constants and the hazard-unit state type
package hazard_detection_unit_pkg;
  localparam int REG_W = 4;
  localparam int CNT_W = 16;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} hdu_state_t;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline hazard bus between datapath (master) and hazard unit (slave)
//   master drives ID/EX operand info, branch/halt/memory-busy status; slave returns stall/flush
//   controls, the sticky halted flag and the stall/flush performance counters.
interface hazard_detection_unit_if;
  import hazard_detection_unit_pkg::*;
  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             IF_ID_UsesRt;
  logic             IF_ID_MemWrite;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] ID_EX_Rd;
  logic             EX_BranchTaken;
  logic             IF_Halt;
  logic             IMem_busy;
  logic             DMem_busy;
  logic             PC_stall;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_stall;
  logic             MEM_WB_stall;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_MemWrite, ID_EX_MemRead, ID_EX_Rd,
           EX_BranchTaken, IF_Halt, IMem_busy, DMem_busy,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall, MEM_WB_stall,
           halted, stall_cycles, flush_count
  );
  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_MemWrite, ID_EX_MemRead, ID_EX_Rd,
           EX_BranchTaken, IF_Halt, IMem_busy, DMem_busy,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall, MEM_WB_stall,
           halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// hazard_detection_unit_sat_counter: saturating up-counter with sync active-low reset
//   clk, rst_n: clock / sync reset; en_i: count this cycle; cnt_o: current count (sticks at all-ones)
module hazard_detection_unit_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: ID-stage stall/flush controller (load-use, branch squash, memory freeze, halt)
//   clk, rst_n : pipeline clock, sync active-low reset
//   hif        : slave side of the hazard bus (operand/status in, stall/flush/halted/counters out)
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_detection_unit_if.slave hif
);
  hdu_state_t state_q, state_d;
  logic       pend_flush_q, pend_flush_d;
  logic       draining_q, draining_d;
  logic [1:0] drain_q, drain_d;
  logic       run, load_use, br, halt_req;
  logic       frz, fl, hlt, im, lu, hd;
  assign run = rst_n && state_q != HALT;
  // Rt-only match on a store is left to the MEM-stage store-data forward
  assign load_use = hif.ID_EX_MemRead && hif.ID_EX_Rd != REG_ZERO &&
                    (hif.ID_EX_Rd == hif.IF_ID_Rs ||
                     (hif.IF_ID_UsesRt && hif.ID_EX_Rd == hif.IF_ID_Rt && !hif.IF_ID_MemWrite));
  assign br       = hif.EX_BranchTaken | pend_flush_q;
  assign halt_req = hif.IF_Halt | draining_q;
  // one-hot priority: HALT, DMem freeze, branch, halt drain, IMem, load-use
  assign hd  = rst_n && state_q == HALT;
  assign frz = run & hif.DMem_busy;
  assign fl  = run & ~hif.DMem_busy & br;
  assign hlt = run & ~hif.DMem_busy & ~br & halt_req;
  assign im  = run & ~hif.DMem_busy & ~br & ~halt_req & hif.IMem_busy;
  assign lu  = run & ~hif.DMem_busy & ~br & ~halt_req & ~hif.IMem_busy & load_use;
  assign hif.PC_stall     = frz | hlt | im | lu | hd;
  assign hif.IF_ID_stall  = frz | lu | hd;
  assign hif.IF_ID_flush  = fl | hlt | im;
  assign hif.ID_EX_flush  = fl | lu;
  assign hif.EX_MEM_stall = frz;
  assign hif.MEM_WB_stall = frz;
  assign hif.halted       = state_q == HALT;
  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    draining_d   = draining_q;
    drain_d      = drain_q;
    if (state_q != HALT) begin
      // a branch seen during the freeze is remembered and squashed once memory is free
      pend_flush_d = hif.DMem_busy & br;
      draining_d   = hif.DMem_busy ? draining_q : hlt;
      drain_d      = hif.DMem_busy ? drain_q : (hlt && draining_q) ? drain_q + 2'd1 : 2'd0;
      state_d      = hif.DMem_busy ? MEM_WAIT : (hlt && draining_q && drain_q == 2'd2) ? HALT : RUN;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
      draining_q   <= 1'b0;
      drain_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      draining_q   <= draining_d;
      drain_q      <= drain_d;
    end
  hazard_detection_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(hif.PC_stall & run), .cnt_o(hif.stall_cycles)
  );
  hazard_detection_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(fl), .cnt_o(hif.flush_count)
  );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed self-checking bench for hazard_detection_unit
module tb_hazard_detection_unit;
  import hazard_detection_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  hazard_detection_unit_if hif();
  hazard_detection_unit dut (.clk(clk), .rst_n(rst_n), .hif(hif));
  always #5 clk = ~clk;
  logic [5:0] outs;
  assign outs = {hif.PC_stall, hif.IF_ID_stall, hif.IF_ID_flush, hif.ID_EX_flush,
                 hif.EX_MEM_stall, hif.MEM_WB_stall};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    hif.IF_ID_Rs = '0; hif.IF_ID_Rt = '0; hif.IF_ID_UsesRt = 1'b0; hif.IF_ID_MemWrite = 1'b0;
    hif.ID_EX_MemRead = 1'b0; hif.ID_EX_Rd = '0; hif.EX_BranchTaken = 1'b0;
    hif.IF_Halt = 1'b0; hif.IMem_busy = 1'b0; hif.DMem_busy = 1'b0;
  endtask
  task automatic do_rst();
    rst_n = 1'b0;
    clr();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    clr();
    hif.DMem_busy = 1'b1; hif.IF_Halt = 1'b1; hif.EX_BranchTaken = 1'b1;
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL rst_outs got=%b exp=%b", outs, 6'b000000); end
    tick();
    rst_n = 1'b1;
    clr();
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL rst_idle got=%b exp=%b", outs, 6'b000000); end
    n_cmp++; if (hif.halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got=%b exp=0", hif.halted); end
    n_cmp++; if (hif.stall_cycles !== 16'h0) begin n_bad++; $display("FAIL rst_stall_cnt got=%h exp=0000", hif.stall_cycles); end
    n_cmp++; if (hif.flush_count !== 16'h0) begin n_bad++; $display("FAIL rst_flush_cnt got=%h exp=0000", hif.flush_count); end
  endtask
  task automatic test_load_use();
    do_rst();
    hif.ID_EX_MemRead = 1'b1; hif.ID_EX_Rd = 4'd3;
    hif.IF_ID_Rs = 4'd3; hif.IF_ID_Rt = 4'd5; hif.IF_ID_UsesRt = 1'b1;
    #4;
    n_cmp++; if (outs !== 6'b110100) begin n_bad++; $display("FAIL lu_rs got=%b exp=%b", outs, 6'b110100); end
    tick();
    hif.ID_EX_MemRead = 1'b0;
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL lu_clear got=%b exp=%b", outs, 6'b000000); end
    n_cmp++; if (hif.stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", hif.stall_cycles); end
    hif.ID_EX_MemRead = 1'b1; hif.ID_EX_Rd = 4'd5; hif.IF_ID_Rs = 4'd1;
    #1;
    n_cmp++; if (outs !== 6'b110100) begin n_bad++; $display("FAIL lu_rt got=%b exp=%b", outs, 6'b110100); end
  endtask
  task automatic test_no_stall();
    logic [4:0] vec [4];
    vec[0] = {4'd3, 1'b1};
    vec[1] = {4'd0, 1'b0};
    vec[2] = {4'd3, 1'b0};
    vec[3] = {4'd7, 1'b0};
    do_rst();
    hif.ID_EX_MemRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hif.ID_EX_Rd = vec[i][4:1];
      hif.IF_ID_MemWrite = vec[i][0];
      hif.IF_ID_UsesRt = (i != 2);
      hif.IF_ID_Rs = (i == 1) ? 4'd0 : 4'd1;
      hif.IF_ID_Rt = (i == 3) ? 4'd6 : vec[i][4:1];
      #1;
      n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL nostall_%0d got=%b exp=%b", i, outs, 6'b000000); end
    end
  endtask
  task automatic test_dmem_branch();
    do_rst();
    for (int i = 0; i < 4; i++) begin
      hif.DMem_busy = 1'b1; hif.EX_BranchTaken = (i == 0);
      #4;
      n_cmp++; if (outs !== 6'b110011) begin n_bad++; $display("FAIL freeze_%0d got=%b exp=%b", i, outs, 6'b110011); end
      tick();
    end
    clr();
    #4;
    n_cmp++; if (outs !== 6'b001100) begin n_bad++; $display("FAIL pend_flush got=%b exp=%b", outs, 6'b001100); end
    tick();
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL post_flush got=%b exp=%b", outs, 6'b000000); end
    n_cmp++; if (hif.flush_count !== 16'd1) begin n_bad++; $display("FAIL dm_flush_cnt got=%0d exp=1", hif.flush_count); end
    n_cmp++; if (hif.stall_cycles !== 16'd4) begin n_bad++; $display("FAIL dm_stall_cnt got=%0d exp=4", hif.stall_cycles); end
  endtask
  task automatic test_imem_priority();
    do_rst();
    for (int i = 0; i < 2; i++) begin
      hif.IMem_busy = 1'b1;
      hif.ID_EX_MemRead = 1'b1; hif.ID_EX_Rd = 4'd2; hif.IF_ID_Rs = 4'd2;
      #4;
      n_cmp++; if (outs !== 6'b101000) begin n_bad++; $display("FAIL imem_%0d got=%b exp=%b", i, outs, 6'b101000); end
      tick();
    end
    hif.EX_BranchTaken = 1'b1;
    #4;
    n_cmp++; if (outs !== 6'b001100) begin n_bad++; $display("FAIL br_over_imem got=%b exp=%b", outs, 6'b001100); end
  endtask
  task automatic test_halt();
    do_rst();
    hif.IF_Halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      n_cmp++; if (outs !== 6'b101000) begin n_bad++; $display("FAIL drain_%0d got=%b exp=%b", i, outs, 6'b101000); end
      n_cmp++; if (hif.halted !== 1'b0) begin n_bad++; $display("FAIL drain_halted_%0d got=%b exp=0", i, hif.halted); end
      tick();
      hif.IF_Halt = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      hif.EX_BranchTaken = (i == 1); hif.DMem_busy = (i == 2);
      #4;
      n_cmp++; if (hif.halted !== 1'b1) begin n_bad++; $display("FAIL halted_%0d got=%b exp=1", i, hif.halted); end
      n_cmp++; if (outs !== 6'b110000) begin n_bad++; $display("FAIL halt_outs_%0d got=%b exp=%b", i, outs, 6'b110000); end
      tick();
    end
    n_cmp++; if (hif.stall_cycles !== 16'd4) begin n_bad++; $display("FAIL halt_stall_cnt got=%0d exp=4", hif.stall_cycles); end
    n_cmp++; if (hif.flush_count !== 16'd0) begin n_bad++; $display("FAIL halt_flush_cnt got=%0d exp=0", hif.flush_count); end
  endtask
  task automatic test_halt_abort();
    do_rst();
    hif.IF_Halt = 1'b1;
    tick();
    hif.IF_Halt = 1'b0;
    tick();
    hif.EX_BranchTaken = 1'b1;
    #4;
    n_cmp++; if (outs !== 6'b001100) begin n_bad++; $display("FAIL abort_flush got=%b exp=%b", outs, 6'b001100); end
    tick();
    hif.EX_BranchTaken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      n_cmp++; if (hif.halted !== 1'b0 || outs !== 6'b000000) begin
        n_bad++; $display("FAIL abort_%0d halted=%b outs=%b exp halted=0 outs=000000", i, hif.halted, outs);
      end
      tick();
    end
    n_cmp++; if (hif.flush_count !== 16'd1) begin n_bad++; $display("FAIL abort_flush_cnt got=%0d exp=1", hif.flush_count); end
  endtask
  task automatic test_saturate_reset();
    do_rst();
    hif.DMem_busy = 1'b1;
    repeat (70000) tick();
    #4;
    n_cmp++; if (hif.stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_stall_cnt got=%h exp=ffff", hif.stall_cycles); end
    tick();
    rst_n = 1'b0;
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL midrst_outs got=%b exp=%b", outs, 6'b000000); end
    tick();
    rst_n = 1'b1;
    clr();
    #4;
    n_cmp++; if (outs !== 6'b000000) begin n_bad++; $display("FAIL postrst_outs got=%b exp=%b", outs, 6'b000000); end
    n_cmp++; if (hif.stall_cycles !== 16'h0 || hif.flush_count !== 16'h0) begin
      n_bad++; $display("FAIL postrst_cnt stall=%h flush=%h exp 0000/0000", hif.stall_cycles, hif.flush_count);
    end
    n_cmp++; if (hif.halted !== 1'b0) begin n_bad++; $display("FAIL postrst_halted got=%b exp=0", hif.halted); end
  endtask
  initial begin
    clr();
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_dmem_branch();
    test_imem_priority();
    test_halt();
    test_halt_abort();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
